// File: rtl/cbs_tile_scheduler.sv
// -----------------------------------------------------------------------------
// cbs_tile_scheduler
//
// Sequences one CBS layer (conv -> BN -> SiLU) over output-channel tiles so a
// conv engine sized for K_TILE filters can produce K_TOTAL filters. For every
// tile it pulses conv_start, waits for a rising edge on conv_finished, pulses
// bn_latch, lets the fixed BN+SiLU latency elapse, then offers the tile
// downstream over out_valid/out_ready.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   start          in   begin a layer (only honoured while idle)
//   busy           out  high whenever the scheduler is not idle
//   done           out  one-cycle pulse after the final tile is accepted
//   error          out  sticky conv timeout flag, cleared by the next start
//   conv_start     out  one-cycle pulse launching one conv pass
//   conv_finished  in   conv engine Finished level (rising edge = pass done)
//   filt_base      out  first filter index of the current tile
//   tile_k         out  number of valid filters in the current tile
//   bn_latch       out  one-cycle pulse capturing conv output into BN input
//   out_valid      out  current tile is available at the SiLU output
//   out_ready      in   downstream accepts the tile
//   out_last       out  qualifies out_valid: this is the final tile
//
// All outputs come straight from flops; none depends combinationally on an
// input.
// -----------------------------------------------------------------------------
module cbs_tile_scheduler #(
    parameter int K_TOTAL = 13,
    parameter int K_TILE  = 4,
    parameter int BN_LAT  = 2,
    parameter int ACT_LAT = 2,
    parameter int TIMEOUT = 4096,
    localparam int CW     = $clog2(K_TOTAL + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          conv_start,
    input  logic          conv_finished,
    output logic [CW-1:0] filt_base,
    output logic [CW-1:0] tile_k,
    output logic          bn_latch,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
);

    localparam int P  = BN_LAT + ACT_LAT;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [PW-1:0] P_LAST    = PW'((P > 0) ? (P - 1) : 0);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [CW:0]   K_TOTAL_W = (CW + 1)'(K_TOTAL);
    localparam logic [CW:0]   K_TILE_W  = (CW + 1)'(K_TILE);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_CONV_WAIT = 3'd2;
    localparam logic [2:0] ST_LATCH     = 3'd3;
    localparam logic [2:0] ST_PIPE      = 3'd4;
    localparam logic [2:0] ST_OUT       = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    // Filters in the tile starting at base: full tile, or the remainder.
    // base is one bit wider than CW so base+K_TILE never wraps.
    function automatic logic [CW-1:0] tile_len(input logic [CW:0] base);
        logic [CW:0] rem;
        rem = K_TOTAL_W - base;
        if (rem > K_TILE_W) begin
            tile_len = K_TILE_W[CW-1:0];
        end else begin
            tile_len = rem[CW-1:0];
        end
    endfunction

    logic [2:0]    state_r;
    logic [2:0]    state_s;
    logic          fin_q_r;
    logic [TW-1:0] wait_cnt_r;
    logic [PW-1:0] pipe_cnt_r;
    logic [CW-1:0] filt_base_r;
    logic [CW-1:0] tile_k_r;
    logic          error_r;
    logic          busy_r;
    logic          done_r;
    logic          conv_start_r;
    logic          bn_latch_r;
    logic          out_valid_r;
    logic          out_last_r;

    logic [CW:0]   next_base_s;
    logic          last_tile_s;
    logic          conv_edge_s;
    logic          timeout_s;
    logic          accept_start_s;
    logic          advance_s;

    assign next_base_s    = {1'b0, filt_base_r} + K_TILE_W;
    assign last_tile_s    = (next_base_s >= K_TOTAL_W);
    // A Finished level already high when the pass is launched is stale; only a
    // fresh 0->1 transition counts as completion.
    assign conv_edge_s    = conv_finished & ~fin_q_r;
    assign accept_start_s = (state_r == ST_IDLE) && start;
    assign advance_s      = (state_r == ST_OUT) && out_ready && !last_tile_s;

    // Next-state decode for the tile sequencing FSM.
    always_comb begin
        state_s   = state_r;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s = ST_CONV_WAIT;
            end
            ST_CONV_WAIT: begin
                if (conv_edge_s) begin
                    state_s = ST_LATCH;
                end else if (wait_cnt_r == TO_LAST) begin
                    state_s   = ST_IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = ST_CONV_WAIT;
                end
            end
            ST_LATCH: begin
                if (P == 0) begin
                    state_s = ST_OUT;
                end else begin
                    state_s = ST_PIPE;
                end
            end
            ST_PIPE: begin
                if (pipe_cnt_r == P_LAST) begin
                    state_s = ST_OUT;
                end else begin
                    state_s = ST_PIPE;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (last_tile_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and conv_finished history for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            fin_q_r <= 1'b0;
        end else begin
            state_r <= state_s;
            fin_q_r <= conv_finished;
        end
    end

    // Cycle counters for the conv wait window and the BN+SiLU pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= {TW{1'b0}};
            pipe_cnt_r <= {PW{1'b0}};
        end else begin
            if (state_r == ST_CONV_WAIT) begin
                wait_cnt_r <= wait_cnt_r + TW'(1);
            end else begin
                wait_cnt_r <= {TW{1'b0}};
            end
            if (state_r == ST_PIPE) begin
                pipe_cnt_r <= pipe_cnt_r + PW'(1);
            end else begin
                pipe_cnt_r <= {PW{1'b0}};
            end
        end
    end

    // Tile descriptor: set for tile 0 on start, stepped on each non-final
    // transfer, otherwise held so it is stable from LOAD through OUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_base_r <= {CW{1'b0}};
            tile_k_r    <= {CW{1'b0}};
        end else if (accept_start_s) begin
            filt_base_r <= {CW{1'b0}};
            tile_k_r    <= tile_len({(CW + 1){1'b0}});
        end else if (advance_s) begin
            filt_base_r <= next_base_s[CW-1:0];
            tile_k_r    <= tile_len(next_base_s);
        end else begin
            filt_base_r <= filt_base_r;
            tile_k_r    <= tile_k_r;
        end
    end

    // Sticky timeout flag; a newly accepted layer clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_r <= 1'b0;
        end else if (accept_start_s) begin
            error_r <= 1'b0;
        end else if (timeout_s) begin
            error_r <= 1'b1;
        end else begin
            error_r <= error_r;
        end
    end

    // Output flops, loaded from the next state so they line up with state_r.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            conv_start_r <= 1'b0;
            bn_latch_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
        end else begin
            busy_r       <= (state_s != ST_IDLE);
            done_r       <= (state_s == ST_DONE);
            conv_start_r <= (state_s == ST_LOAD);
            bn_latch_r   <= (state_s == ST_LATCH);
            out_valid_r  <= (state_s == ST_OUT);
            // filt_base_r only changes when leaving OUT, so it describes the
            // tile being presented whenever state_s is OUT.
            out_last_r   <= (state_s == ST_OUT) && last_tile_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign conv_start = conv_start_r;
    assign bn_latch   = bn_latch_r;
    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign filt_base  = filt_base_r;
    assign tile_k     = tile_k_r;

endmodule
